cbuf_reader: RTL

Consumer-side controller for the 16-bit circular sample buffer. It mirrors the buffer's occupancy from the producer's write strobe and issues read enables only when data is present. It captures the buffer's registered read data into a 3-entry output queue and presents samples downstream on a valid/ready stream. It sits between the circular buffer and the next DSP stage (filter or frame processor).

---
 rtl/cbuf_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cbuf_reader.sv
// Consumer-side reader for the circular sample buffer: occupancy mirror, read issue, 3-entry output queue.
// Optional burst framing (reads gated per BURST-sample frame, m_last tagging) when CBUF_RD_BURST_EN is defined.
module cbuf_reader #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 16,
  parameter int BURST  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_mon,
  output logic                      fifo_r_en,
  input  logic [DATA_W-1:0]         fifo_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_last,
  output logic [$clog2(DEPTH):0]    occ,
  output logic                      ovf
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic              issue_ok;
  logic              rd_allowed;
  logic              rd_last;
  logic              pend_p0;
  logic              pend_last_p0;
  logic [1:0]        q_cnt;
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [DATA_W-1:0] q_data [3];
  logic              q_last [3];
  logic              push;
  logic              pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts queued entries plus the read still in flight, so no m_ready path reaches fifo_r_en.
  assign issue_ok  = (occ != '0) && !wr_mon && (({1'b0, q_cnt} + {2'b00, pend_p0}) < 3'd3);
  assign fifo_r_en = rd_allowed && issue_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
      ovf <= 1'b0;
    end else if (wr_mon) begin
      if (occ != OW'(DEPTH)) occ <= occ + OW'(1);
      else                   ovf <= 1'b1;
    end else if (fifo_r_en) begin
      occ <= occ - OW'(1);
    end
  end

`ifdef CBUF_RD_BURST_EN
  localparam int RW = $clog2(BURST + 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t        state, state_nxt;
  logic [RW-1:0] rem, rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    rd_allowed = 1'b0;
    rd_last    = 1'b0;
    case (state)
      IDLE: begin
        if (occ >= OW'(BURST)) begin
          state_nxt = RUN;
          rem_nxt   = RW'(BURST);
        end
      end
      RUN: begin
        rd_allowed = 1'b1;
        if (issue_ok) begin
          rem_nxt = rem - RW'(1);
          if (rem == RW'(1)) begin
            rd_last   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign rd_allowed = 1'b1;
  assign rd_last    = 1'b0;
`endif

  // Stage p0: read issued last cycle; buffer data is valid now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_p0      <= 1'b0;
      pend_last_p0 <= 1'b0;
    end else begin
      pend_p0      <= fifo_r_en;
      pend_last_p0 <= rd_last;
    end
  end

  assign push = pend_p0;
  assign pop  = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      q_cnt <= q_cnt + 2'd1;
      else if (!push && pop) q_cnt <= q_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= fifo_data;
      q_last[wr_ptr] <= pend_last_p0;
    end
  end

  // Head is gated by valid so outputs read zero after reset without resetting the data array.
  assign m_valid = (q_cnt != 2'd0);
  assign m_data  = m_valid ? q_data[rd_ptr] : '0;
  assign m_last  = m_valid && q_last[rd_ptr];
endmodule
